p2s_lanes: RTL and testbench

//  Parallel-to-serial transmit stage; sits directly upstream of the s2p deserializer.

---
 rtl/p2s_lanes_pkg.sv | 14 +
 rtl/p2s_lane.sv | 46 ++++
 rtl/p2s_lanes.sv | 110 +++++++++++
 tb/tb_p2s_lanes.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_lanes_pkg.sv
// Purpose: shared definitions for the p2s_lanes parallel-to-serial transmitter.
//   Default geometry and the FSM encoding; the encoding is also used by the
//   downstream s2p framing checks, so the values are fixed.
package p2s_lanes_pkg;

    localparam int unsigned P2S_LANES_DEF = 4;
    localparam int unsigned P2S_WIDTH_DEF = 8;

    typedef enum logic {
        P2S_IDLE  = 1'b0,
        P2S_SHIFT = 1'b1
    } p2s_state_e;

endpackage

// File: rtl/p2s_lane.sv
// Purpose: one serial lane, a WIDTH-bit load/shift register, MSB first.
// Ports:
//   CLK        clock, all updates on posedge
//   reset      asynchronous active-low reset
//   ENB        enable; low freezes the lane
//   load       present load_data MSB now, keep the rest for shifting
//   shift      present the next stored bit
//   clear      drive the serial output low (line idle)
//   load_data  WIDTH-bit word to serialize
//   s_bit      registered serial output
module p2s_lane
    import p2s_lanes_pkg::*;
#(
    parameter int unsigned WIDTH = P2S_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             ENB,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic             s_bit
);

    logic [WIDTH-1:0] shifter;

    // Serial bit is registered alongside the shifter so it leaves on the load edge.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            shifter <= '0;
            s_bit   <= 1'b0;
        end else if (ENB) begin
            if (load) begin
                s_bit   <= load_data[WIDTH-1];
                shifter <= load_data << 1;
            end else if (shift) begin
                s_bit   <= shifter[WIDTH-1];
                shifter <= shifter << 1;
            end else if (clear) begin
                s_bit   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/p2s_lanes.sv
// Purpose: multi-lane parallel-to-serial transmit stage feeding the s2p deserializer.
//   One word set (LANES bytes) per valid/ready handshake, each byte shifted out
//   MSB-first on its own lane; frame_out marks the MSB of every byte. A one-entry
//   hold register allows back-to-back word sets with no gap bits.
// Ports:
//   CLK        clock
//   reset      asynchronous active-low reset
//   ENB        enable; low freezes all state and blocks acceptance
//   data_in    lane k byte = data_in[k*WIDTH +: WIDTH]
//   in_valid   data_in valid this cycle
//   in_ready   combinational: ENB & ~hold_full
//   s_out      registered serial bit per lane
//   frame_out  registered; high while the MSB of a word is on s_out
//   busy       registered; high while shifting
//   underrun   registered one-cycle pulse when a word ends with nothing held
module p2s_lanes
    import p2s_lanes_pkg::*;
#(
    parameter int unsigned LANES = P2S_LANES_DEF,
    parameter int unsigned WIDTH = P2S_WIDTH_DEF
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   ENB,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES-1:0]       s_out,
    output logic                   frame_out,
    output logic                   busy,
    output logic                   underrun
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    p2s_state_e             state;
    // Index of the bit currently on s_out, counted from the MSB (0 = MSB).
    logic [CNT_W-1:0]       bit_cnt;
    logic [LANES*WIDTH-1:0] hold;
    logic                   hold_full;

    logic accept_c;
    logic last_c;
    logic load_c;
    logic shift_c;
    logic idle_c;

    assign in_ready = ENB && !hold_full;

    // Step decode; a load on the last bit gives gap-free streaming.
    always_comb begin
        accept_c = in_valid && in_ready;
        last_c   = (bit_cnt == LAST_BIT);
        load_c   = hold_full && ((state == P2S_IDLE) || last_c);
        shift_c  = (state == P2S_SHIFT) && !last_c;
        idle_c   = (state == P2S_SHIFT) && last_c && !hold_full;
    end

    // Control FSM, hold register and flags.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= P2S_IDLE;
            bit_cnt   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            frame_out <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else if (ENB) begin
            underrun <= 1'b0;
            if (accept_c) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
            if (load_c) begin
                state     <= P2S_SHIFT;
                bit_cnt   <= '0;
                hold_full <= 1'b0;
                frame_out <= 1'b1;
                busy      <= 1'b1;
            end else if (shift_c) begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                frame_out <= 1'b0;
            end else if (idle_c) begin
                state     <= P2S_IDLE;
                frame_out <= 1'b0;
                busy      <= 1'b0;
                underrun  <= 1'b1;
            end
        end
    end

    // One shift register per lane, all stepped by the shared controls.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        p2s_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .CLK      (CLK),
            .reset    (reset),
            .ENB      (ENB),
            .load     (load_c),
            .shift    (shift_c),
            .clear    (idle_c),
            .load_data(hold[k*WIDTH +: WIDTH]),
            .s_bit    (s_out[k])
        );
    end

endmodule

// File: tb/tb_p2s_lanes.sv
// Purpose: directed self-checking bench for p2s_lanes (4 lanes x 8 bits).
module tb_p2s_lanes;

    logic        CLK = 1'b0;
    logic        reset;
    logic        ENB;
    logic [31:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  s_out;
    logic        frame_out;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    p2s_lanes #(
        .LANES(4),
        .WIDTH(8)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .ENB      (ENB),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s_out    (s_out),
        .frame_out(frame_out),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Column of bit b across the four lane bytes of w.
    function automatic logic [3:0] col(input logic [31:0] w, input int b);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = w[k*8 + b];
        return r;
    endfunction

    // Step through bits hi..lo of word w, checking the serial column and flags.
    task automatic expect_bits(input string tag, input logic [31:0] w, input int hi, input int lo);
        for (int b = hi; b >= lo; b--) begin
            tick();
            chk({tag, "_sout"}, 32'(s_out), 32'(col(w, b)));
            chk({tag, "_frame"}, 32'(frame_out), 32'(b == 7));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_unr"}, 32'(underrun), 32'd0);
        end
    endtask

    // Word ended with nothing held: one underrun pulse, line idle.
    task automatic expect_underrun(input string tag);
        tick();
        chk({tag, "_unr_hi"}, 32'(underrun), 32'd1);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        chk({tag, "_sout_0"}, 32'(s_out), 32'd0);
        chk({tag, "_frame_0"}, 32'(frame_out), 32'd0);
        tick();
        chk({tag, "_unr_lo"}, 32'(underrun), 32'd0);
    endtask

    logic [3:0]  exp_a [8];
    logic [31:0] wa;
    logic [31:0] wb;
    logic [7:0]  sh [4];
    logic [7:0]  eb;
    int          wi;
    int          rx;
    int          bi;
    logic        accepted;

    initial begin
        // hand-derived columns {lane3..lane0} of 32'hA53C0F81, MSB first
        exp_a = '{4'b1001, 4'b0000, 4'b1100, 4'b0100,
                  4'b0110, 4'b1110, 4'b0010, 4'b1011};

        // ---- 1. reset, including mid-word with a held word ----
        reset    = 1'b0;
        ENB      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        #12;
        chk("rst_sout", 32'(s_out), 32'd0);
        chk("rst_frame", 32'(frame_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_unr", 32'(underrun), 32'd0);
        chk("rst_rdy_enb0", 32'(in_ready), 32'd0);
        reset = 1'b1;
        ENB   = 1'b1;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("rel_busy", 32'(busy), 32'd0);

        data_in  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();                      // accept
        in_valid = 1'b0;
        tick();                      // bit 7
        tick();                      // bit 6
        data_in  = 32'h1234_5678;
        in_valid = 1'b1;
        tick();                      // bit 5, second word held
        in_valid = 1'b0;
        tick();                      // bit 4
        tick();                      // bit 3
        chk("mid_sout", 32'(s_out), 32'hF);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_rdy_full", 32'(in_ready), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("arst_sout", 32'(s_out), 32'd0);
        chk("arst_frame", 32'(frame_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        ENB = 1'b0;
        #1;
        chk("arst_rdy_enb0", 32'(in_ready), 32'd0);
        reset = 1'b1;
        ENB   = 1'b1;
        #1;
        chk("arst_rdy_rel", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("discard_sout", 32'(s_out), 32'd0);
            chk("discard_busy", 32'(busy), 32'd0);
            chk("discard_frame", 32'(frame_out), 32'd0);
        end

        // ---- 2. single word ----
        data_in  = 32'hA53C_0F81;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sw_lat_sout", 32'(s_out), 32'd0);
        chk("sw_lat_busy", 32'(busy), 32'd0);
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("sw_sout", 32'(s_out), 32'(exp_a[j]));
            chk("sw_frame", 32'(frame_out), 32'(j == 0));
            chk("sw_busy", 32'(busy), 32'd1);
        end
        expect_underrun("sw");

        // ---- 3. back-to-back ----
        data_in  = 32'h0102_0304;
        in_valid = 1'b1;
        chk("b2b_rdy0", 32'(in_ready), 32'd1);
        tick();                      // accept word 1
        chk("b2b_rdy_full", 32'(in_ready), 32'd0);
        data_in = 32'hFFFF_0000;
        tick();                      // load word 1, no accept
        chk("b2b_rdy_load", 32'(in_ready), 32'd1);
        chk("b2b_w1_b7", 32'(s_out), 32'(col(32'h0102_0304, 7)));
        chk("b2b_w1_frame", 32'(frame_out), 32'd1);
        tick();                      // accept word 2
        in_valid = 1'b0;
        chk("b2b_w1_b6", 32'(s_out), 32'(col(32'h0102_0304, 6)));
        chk("b2b_rdy_full2", 32'(in_ready), 32'd0);
        expect_bits("b2b_w1", 32'h0102_0304, 5, 0);
        expect_bits("b2b_w2", 32'hFFFF_0000, 7, 0);
        expect_underrun("b2b");

        // ---- 4. ENB drop mid-word ----
        wa       = 32'h5AC3_96E1;
        data_in  = wa;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_bits("enb_pre", wa, 7, 4);
        ENB      = 1'b0;
        in_valid = 1'b1;
        data_in  = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("enb_frz_sout", 32'(s_out), 32'(col(wa, 4)));
            chk("enb_frz_frame", 32'(frame_out), 32'd0);
            chk("enb_frz_busy", 32'(busy), 32'd1);
            chk("enb_frz_rdy", 32'(in_ready), 32'd0);
        end
        ENB      = 1'b1;
        in_valid = 1'b0;
        expect_bits("enb_post", wa, 3, 0);
        expect_underrun("enb");

        // ---- 6. hold full: in_ready low, later data_in ignored ----
        wa       = 32'h1122_3344;
        wb       = 32'hC0DE_5A7E;
        data_in  = wa;
        in_valid = 1'b1;
        tick();                      // accept A
        data_in = wb;
        tick();                      // load A
        chk("hf_rdy_after_load", 32'(in_ready), 32'd1);
        tick();                      // accept B
        data_in = 32'h9999_9999;
        chk("hf_rdy_full", 32'(in_ready), 32'd0);
        for (int b = 5; b >= 0; b--) begin
            tick();
            chk("hf_rdy_low", 32'(in_ready), 32'd0);
            chk("hf_a_sout", 32'(s_out), 32'(col(wa, b)));
        end
        tick();                      // load B
        in_valid = 1'b0;
        chk("hf_b_frame", 32'(frame_out), 32'd1);
        chk("hf_b_b7", 32'(s_out), 32'(col(wb, 7)));
        chk("hf_rdy_free", 32'(in_ready), 32'd1);
        expect_bits("hf_b", wb, 6, 0);
        expect_underrun("hf");

        // ---- 5. loopback through a receive model, bytes 0x00..0x4F ----
        wi = 0;
        rx = 0;
        bi = 0;
        for (int k = 0; k < 4; k++) sh[k] = '0;
        for (int cyc = 0; cyc < 400 && rx < 20; cyc++) begin
            in_valid = (wi < 20);
            data_in  = {8'(4*wi + 3), 8'(4*wi + 2), 8'(4*wi + 1), 8'(4*wi)};
            accepted = in_valid && in_ready;
            tick();
            if (accepted) wi++;
            if (wi >= 20) in_valid = 1'b0;
            if (busy) begin
                bi = frame_out ? 0 : bi + 1;
                for (int k = 0; k < 4; k++) sh[k] = {sh[k][6:0], s_out[k]};
                if (bi == 7) begin
                    for (int k = 0; k < 4; k++) begin
                        eb = 8'(4*rx + k);
                        chk("loop_byte", 32'(sh[k]), 32'(eb));
                    end
                    rx++;
                end
            end
        end
        in_valid = 1'b0;
        chk("loop_count", 32'(rx), 32'd20);
        expect_underrun("loop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
